// File: rtl/csa_accum_ctrl.sv
// csa_accum_ctrl: multi-operand accumulator sequencer around a 3:2
// carry-save step. Operands are folded into a redundant sum/carry pair,
// then resolved by a chunked carry-propagate add over WIDTH/CHUNK cycles.
// Optional build macro: CSA_ACCUM_SAT_EN (saturate out_data on overflow).
module csa_accum_ctrl #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 8,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_ops,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             ovf,
  output logic             busy
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   sum_r;
  logic [WIDTH-1:0]   carry_r;
  logic [WIDTH-1:0]   result_r;
  logic [WIDTH-1:0]   out_data_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [IDX_W-1:0]   chunk_idx_r;
  logic               cin_r;
  logic               ovf_r;
  logic               ovf_out_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               busy_r;

  logic [WIDTH-1:0]   maj_s;
  logic [WIDTH-1:0]   sum_nxt_s;
  logic [CHUNK:0]     chunk_sum_s;
  logic [WIDTH-1:0]   done_data_s;

  // One CSA step against the incoming operand and one chunk of the final add.
  always_comb begin
    maj_s       = (sum_r & carry_r) | (sum_r & in_data) | (carry_r & in_data);
    sum_nxt_s   = sum_r ^ carry_r ^ in_data;
    chunk_sum_s = {1'b0, sum_r[int'(chunk_idx_r)*CHUNK +: CHUNK]}
                + {1'b0, carry_r[int'(chunk_idx_r)*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, cin_r};
  end

  // Value presented while the result is being offered.
`ifdef CSA_ACCUM_SAT_EN
  always_comb begin
    done_data_s = result_r;
    if (ovf_r) begin
      done_data_s = {WIDTH{1'b1}};
    end else begin
      done_data_s = result_r;
    end
  end
`else
  always_comb begin
    done_data_s = result_r;
  end
`endif

  // Controller FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      sum_r       <= {WIDTH{1'b0}};
      carry_r     <= {WIDTH{1'b0}};
      result_r    <= {WIDTH{1'b0}};
      out_data_r  <= {WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      chunk_idx_r <= {IDX_W{1'b0}};
      cin_r       <= 1'b0;
      ovf_r       <= 1'b0;
      ovf_out_r   <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          out_valid_r <= 1'b0;
          if (start) begin
            busy_r <= 1'b1;
            if (num_ops != {CNT_W{1'b0}}) begin
              sum_r      <= {WIDTH{1'b0}};
              carry_r    <= {WIDTH{1'b0}};
              ovf_r      <= 1'b0;
              cnt_r      <= num_ops;
              in_ready_r <= 1'b1;
              state_r    <= ACCUM;
            end else begin
              // Empty job: the result is trivially zero.
              result_r   <= {WIDTH{1'b0}};
              ovf_r      <= 1'b0;
              in_ready_r <= 1'b0;
              state_r    <= DONE;
            end
          end else begin
            busy_r     <= 1'b0;
            in_ready_r <= 1'b0;
          end
        end
        ACCUM: begin
          if (in_valid && in_ready_r) begin
            sum_r   <= sum_nxt_s;
            carry_r <= maj_s << 1;
            // A carry shifted out of the top bit is worth 2^WIDTH.
            ovf_r   <= ovf_r | maj_s[WIDTH-1];
            cnt_r   <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
              chunk_idx_r <= {IDX_W{1'b0}};
              cin_r       <= 1'b0;
              in_ready_r  <= 1'b0;
              state_r     <= RESOLVE;
            end else begin
              state_r <= ACCUM;
            end
          end else begin
            state_r <= ACCUM;
          end
        end
        RESOLVE: begin
          result_r[int'(chunk_idx_r)*CHUNK +: CHUNK] <= chunk_sum_s[CHUNK-1:0];
          cin_r       <= chunk_sum_s[CHUNK];
          chunk_idx_r <= chunk_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
          if (chunk_idx_r == IDX_W'(NCH-1)) begin
            ovf_r   <= ovf_r | chunk_sum_s[CHUNK];
            state_r <= DONE;
          end else begin
            state_r <= RESOLVE;
          end
        end
        DONE: begin
          if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            ovf_out_r   <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
            out_data_r  <= done_data_s;
            ovf_out_r   <= ovf_r;
            state_r     <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign ovf       = ovf_out_r;
  assign busy      = busy_r;

endmodule
